// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target decoding [S|addr7+RW|reg8|data8...] into an 8-bit register file; define AUTOINC_EN for pointer auto-increment
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1101001,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
  output logic addressed,
  output logic wr_strobe,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0] wr_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK} state_t;
  state_t state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl, sda, rise, fall, start, stop, byte_done, wr_en;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, rd_byte;
  logic [AW-1:0] ptr_q, ptr_d, ptr_nx, wr_addr_q;
  logic rw_q, rw_d, sda_oe_q, sda_oe_d, addressed_q, addressed_d, wr_strobe_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [DEPTH];
  assign scl = scl_sync_q[1];
  assign sda = sda_sync_q[1];
  assign rise = scl & ~scl_prev_q;
  assign fall = ~scl & scl_prev_q;
  assign start = scl & sda_prev_q & ~sda;
  assign stop = scl & ~sda_prev_q & sda;
  assign byte_done = fall && cnt_q == 4'd8;
  assign rd_byte = regs_q[ptr_q];
`ifdef AUTOINC_EN
  assign ptr_nx = ptr_q + 1'b1;
`else
  assign ptr_nx = ptr_q;
`endif
  assign sda_oe = sda_oe_q;
  assign addressed = addressed_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  // Synchronise the bus lines and keep one history sample for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl;
      sda_prev_q <= sda;
    end
  end
  // FSM state and transfer datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      ptr_q <= '0;
      rw_q <= 1'b0;
      sda_oe_q <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      ptr_q <= ptr_d;
      rw_q <= rw_d;
      sda_oe_q <= sda_oe_d;
      addressed_q <= addressed_d;
    end
  end
  // Register file and write-report outputs; the write lands on the ACK SCL fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      wr_strobe_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_strobe_q <= wr_en;
      if (wr_en) begin
        regs_q[ptr_q] <= shift_q;
        wr_addr_q <= ptr_q;
        wr_data_q <= shift_q;
      end
    end
  end
  // Next state: bus START/STOP pre-empt any bit-level progress
  always_comb begin
    state_d = state_q;
    if (stop) state_d = IDLE;
    else if (start) state_d = ADDR;
    else case (state_q)
      ADDR: if (byte_done) state_d = (shift_q[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
      ADDR_ACK: if (fall) state_d = rw_q ? RDATA : REG;
      REG: if (byte_done) state_d = REG_ACK;
      REG_ACK: if (fall) state_d = WDATA;
      WDATA: if (byte_done) state_d = WDATA_ACK;
      WDATA_ACK: if (fall) state_d = WDATA;
      RDATA: if (byte_done) state_d = RDATA_ACK;
      RDATA_ACK: if (rise) state_d = sda ? IDLE : RDATA;
      default: ;
    endcase
  end
  // Datapath and SDA drive: sample on SCL rise, change SDA only after SCL fall
  always_comb begin
    cnt_d = cnt_q;
    shift_d = shift_q;
    ptr_d = ptr_q;
    rw_d = rw_q;
    sda_oe_d = sda_oe_q;
    addressed_d = addressed_q;
    wr_en = 1'b0;
    if (stop) begin
      sda_oe_d = 1'b0;
      addressed_d = 1'b0;
    end else if (start) begin
      cnt_d = '0;
      sda_oe_d = 1'b0;
      addressed_d = 1'b0;
    end else case (state_q)
      ADDR, REG, WDATA:
        if (rise) begin
          shift_d = {shift_q[6:0], sda};
          cnt_d = cnt_q + 4'd1;
        end else if (byte_done) begin
          cnt_d = '0;
          if (state_q == ADDR && shift_q[7:1] == SLAVE_ADDR) begin
            rw_d = shift_q[0];
            sda_oe_d = 1'b1;
            addressed_d = 1'b1;
          end
          if (state_q == REG) begin
            ptr_d = shift_q[AW-1:0];
            sda_oe_d = 1'b1;
          end
          if (state_q == WDATA) begin
            wr_en = 1'b1;
            sda_oe_d = 1'b1;
          end
        end
      ADDR_ACK:
        if (fall) begin
          sda_oe_d = rw_q & ~rd_byte[7];
          shift_d = rw_q ? {rd_byte[6:0], 1'b0} : shift_q;
          cnt_d = rw_q ? 4'd1 : 4'd0;
        end
      REG_ACK:
        if (fall) begin
          sda_oe_d = 1'b0;
          cnt_d = '0;
        end
      WDATA_ACK:
        if (fall) begin
          sda_oe_d = 1'b0;
          cnt_d = '0;
          ptr_d = ptr_nx;
        end
      RDATA:
        if (fall) begin
          sda_oe_d = (cnt_q == 4'd8) ? 1'b0 : ~shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
          cnt_d = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
        end
      RDATA_ACK:
        if (rise) begin
          addressed_d = ~sda;
          ptr_d = sda ? ptr_q : ptr_nx;
          shift_d = sda ? shift_q : regs_q[ptr_nx];
          cnt_d = '0;
        end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: directed I2C master frames against i2c_slave_regfile with immediate-assertion checks
module tb_i2c_slave_regfile;
  localparam int Q = 50;
`ifdef AUTOINC_EN
  localparam logic [3:0] EXP_LAST_ADDR = 4'd0;
  localparam logic [7:0] EXP_RD1 = 8'h11;
`else
  localparam logic [3:0] EXP_LAST_ADDR = 4'd15;
  localparam logic [7:0] EXP_RD1 = 8'h22;
`endif
  logic clk = 1'b0, reset = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic sda_oe, addressed, wr_strobe, sda_bus, ack, s;
  logic [3:0] wr_addr, last_addr = '0;
  logic [7:0] wr_data, last_data = '0, rd;
  int n_tests = 0, n_fail = 0, n_strobe = 0, base;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regfile dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .addressed(addressed), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_strobe) begin
    n_strobe <= n_strobe + 1;
    last_addr <= wr_addr;
    last_data <= wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_x(input logic b, output logic smp);
    sda_m = b; #Q;
    scl = 1'b1; #Q;
    smp = sda_bus; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    logic t;
    for (int i = 7; i >= 0; i--) bit_x(b[i], t);
    bit_x(1'b1, t);
    a = ~t;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, t);
      d[i] = t;
    end
    bit_x(nack, t);
  endtask

  task automatic start_c;
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic stop_c;
    sda_m = 1'b0; #Q;
    scl = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  initial begin
    #(2*Q);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_addressed", addressed, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 1'b0;
    #(2*Q);
    // write A5 to reg 3
    start_c;
    send_byte(8'hD2, ack); chk("wr_addr_ack", ack, 1);
    chk("wr_addressed", addressed, 1);
    send_byte(8'h03, ack); chk("wr_reg_ack", ack, 1);
    send_byte(8'hA5, ack); chk("wr_data_ack", ack, 1);
    chk("wr_strobes", n_strobe, 1);
    chk("wr_strobe_addr", last_addr, 3);
    chk("wr_strobe_data", last_data, 8'hA5);
    stop_c;
    #Q;
    chk("wr_stop_addressed", addressed, 0);
    // read reg 3 back through a repeated START
    start_c;
    send_byte(8'hD2, ack); chk("rd_addr_ack", ack, 1);
    send_byte(8'h03, ack); chk("rd_reg_ack", ack, 1);
    start_c;
    send_byte(8'hD3, ack); chk("rd_addr_r_ack", ack, 1);
    read_byte(1'b1, rd); chk("rd_data", rd, 8'hA5);
    chk("rd_nack_sda_oe", sda_oe, 0);
    chk("rd_nack_addressed", addressed, 0);
    stop_c;
    // wrong address: no ACK, no writes
    base = n_strobe;
    start_c;
    send_byte(8'h40, ack); chk("bad_addr_ack", ack, 0);
    chk("bad_addressed", addressed, 0);
    send_byte(8'h03, ack); chk("bad_reg_ack", ack, 0);
    send_byte(8'h77, ack); chk("bad_data_ack", ack, 0);
    stop_c;
    chk("bad_strobes", n_strobe - base, 0);
    // burst write starting at the last register
    base = n_strobe;
    start_c;
    send_byte(8'hD2, ack);
    send_byte(8'h0F, ack);
    send_byte(8'h11, ack); chk("burst_ack1", ack, 1);
    send_byte(8'h22, ack); chk("burst_ack2", ack, 1);
    stop_c;
    chk("burst_strobes", n_strobe - base, 2);
    chk("burst_last_addr", last_addr, EXP_LAST_ADDR);
    chk("burst_last_data", last_data, 8'h22);
    start_c;
    send_byte(8'hD2, ack);
    send_byte(8'h0F, ack);
    start_c;
    send_byte(8'hD3, ack);
    read_byte(1'b0, rd); chk("burst_rd1", rd, EXP_RD1);
    read_byte(1'b1, rd); chk("burst_rd2", rd, 8'h22);
    stop_c;
    // STOP after 4 data bits aborts the write
    base = n_strobe;
    start_c;
    send_byte(8'hD2, ack);
    send_byte(8'h05, ack);
    bit_x(1'b1, s); bit_x(1'b0, s); bit_x(1'b1, s); bit_x(1'b1, s);
    stop_c;
    chk("abort_strobes", n_strobe - base, 0);
    start_c;
    send_byte(8'hD2, ack);
    send_byte(8'h05, ack);
    start_c;
    send_byte(8'hD3, ack);
    read_byte(1'b1, rd); chk("abort_reg5", rd, 8'h00);
    stop_c;
    // reset in the middle of a read while the target is pulling SDA low
    start_c;
    send_byte(8'hD2, ack);
    send_byte(8'h03, ack);
    start_c;
    send_byte(8'hD3, ack);
    bit_x(1'b1, s); chk("mid_rd_bit7", s, 1);
    chk("mid_rd_oe_bit6", sda_oe, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_sda_oe", sda_oe, 0);
    chk("mid_rst_addressed", addressed, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    sda_m = 1'b1;
    scl = 1'b1;
    #(Q-1);
    reset = 1'b0;
    #Q;
    start_c;
    send_byte(8'hD2, ack);
    send_byte(8'h03, ack);
    start_c;
    send_byte(8'hD3, ack); chk("post_rst_ack", ack, 1);
    read_byte(1'b1, rd); chk("post_rst_reg3", rd, 8'h00);
    stop_c;
    #Q;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
